// File: rtl/rv32_csr_arbiter.sv
// rv32_csr_arbiter: round-robin arbiter sharing the single-port CSR file
// between N_REQ requesters. A requester may lock the grant across a
// multi-access atomic sequence (e.g. mcycle/mcycleh).
// Optional macro CSR_ARB_HOSTPRIO_EN: requester 0 gets absolute priority in
// ARB and round-robin rotates only among requesters 1..N_REQ-1.
module rv32_csr_arbiter #(
  parameter int          N_REQ   = 4,
  parameter logic [2:0]  IDLE_OP = 3'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ-1:0]      req_lock_i,
  input  logic [N_REQ*12-1:0]   req_addr_i,
  input  logic [N_REQ*32-1:0]   req_wdata_i,
  input  logic [N_REQ*3-1:0]    req_op_i,
  output logic [N_REQ-1:0]      rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_exc_o,
  output logic [11:0]           csr_addr_o,
  output logic [31:0]           csr_wdata_o,
  output logic [2:0]            csr_op_o,
  input  logic [31:0]           csr_rdata_i,
  input  logic                  csr_exc_valid_i
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef CSR_ARB_HOSTPRIO_EN
  // Requester 0 never takes part in the rotation; it wins by priority instead.
  localparam logic [N_REQ-1:0] RR_MASK = ~N_REQ'(1);
`else
  localparam logic [N_REQ-1:0] RR_MASK = '1;
`endif

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_lock_owner;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_exc;

  logic [N_REQ-1:0]  w_rr_req;
  logic              w_rr_found;
  logic [PW-1:0]     w_rr_idx;
  logic              w_win_valid;
  logic [PW-1:0]     w_win_idx;
  int                w_scan;

  assign w_rr_req = req_valid_i & RR_MASK;

  // Winner selection, grant/mux outputs and FSM next state.
  always_comb begin
    w_rr_found  = 1'b0;
    w_rr_idx    = '0;
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_scan      = 0;
    w_state_nxt = r_state;
    req_ready_o = '0;
    csr_addr_o  = '0;
    csr_wdata_o = '0;
    csr_op_o    = IDLE_OP;

    // Search starts one past the last grant so every requester gets a turn.
    for (int i = 1; i <= N_REQ; i++) begin
      w_scan = (int'(r_rr_ptr) + i) % N_REQ;
      if (!w_rr_found && w_rr_req[w_scan]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = PW'(w_scan);
      end
    end

    if (r_state == ST_LOCKED) begin
      w_win_valid = req_valid_i[r_lock_owner];
      w_win_idx   = r_lock_owner;
    end else begin
      w_win_valid = w_rr_found;
      w_win_idx   = w_rr_idx;
`ifdef CSR_ARB_HOSTPRIO_EN
      if (req_valid_i[0]) begin
        w_win_valid = 1'b1;
        w_win_idx   = '0;
      end
`endif
    end

    // No grant may escape while reset is held.
    w_win_valid = w_win_valid & rst_n;

    if (w_win_valid) begin
      req_ready_o[w_win_idx] = 1'b1;
      csr_addr_o  = req_addr_i[int'(w_win_idx)*12 +: 12];
      csr_wdata_o = req_wdata_i[int'(w_win_idx)*32 +: 32];
      csr_op_o    = req_op_i[int'(w_win_idx)*3 +: 3];
      if (r_state == ST_ARB && req_lock_i[w_win_idx]) begin
        w_state_nxt = ST_LOCKED;
      end else if (r_state == ST_LOCKED && !req_lock_i[w_win_idx]) begin
        w_state_nxt = ST_ARB;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ARB;
    else        r_state <= w_state_nxt;
  end

  // Round-robin pointer and lock owner bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_lock_owner <= '0;
    end else if (w_win_valid) begin
`ifdef CSR_ARB_HOSTPRIO_EN
      if (w_win_idx != '0) r_rr_ptr <= w_win_idx;
`else
      r_rr_ptr <= w_win_idx;
`endif
      if (r_state == ST_ARB && req_lock_i[w_win_idx]) r_lock_owner <= w_win_idx;
    end
  end

  // Response register: strobe for one cycle, data held between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_exc   <= 1'b0;
    end else begin
      r_rsp_valid <= req_ready_o;
      if (w_win_valid) begin
        r_rsp_rdata <= csr_rdata_i;
        r_rsp_exc   <= csr_exc_valid_i;
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_exc_o   = r_rsp_exc;

endmodule

// File: tb/tb_rv32_csr_arbiter.sv
// Directed testbench for rv32_csr_arbiter (N_REQ=4, IDLE_OP=0).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_rv32_csr_arbiter;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    r_valid = '0;
  logic [3:0]    r_lock = '0;
  logic [47:0]   r_addr = '0;
  logic [127:0]  r_wdata = '0;
  logic [11:0]   r_op = '0;
  logic [3:0]    ready, rsp_valid;
  logic [31:0]   rsp_rdata, csr_wdata, csr_rdata;
  logic          rsp_exc, exc_drv = 1'b0, use_model = 1'b0;
  logic [11:0]   csr_addr;
  logic [2:0]    csr_op;
  logic [31:0]   rdata_drv = '0;
  int            total = 0;
  int            bad = 0;
  int            g[5] = '{1, 2, 3, 0, 1};
  logic [3:0]    exp_rv;

  always #5 clk = ~clk;

  // Simple CSR file stand-in: read data tags the address it was given.
  assign csr_rdata = use_model ? {20'hCAFE0, csr_addr} : rdata_drv;

  rv32_csr_arbiter #(.N_REQ(4), .IDLE_OP(3'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(r_valid), .req_ready_o(ready), .req_lock_i(r_lock),
    .req_addr_i(r_addr), .req_wdata_i(r_wdata), .req_op_i(r_op),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_exc_o(rsp_exc),
    .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata), .csr_op_o(csr_op),
    .csr_rdata_i(csr_rdata), .csr_exc_valid_i(exc_drv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic l, input logic [11:0] a);
    r_valid[k] = v;
    r_lock[k] = l;
    r_addr[k*12 +: 12] = a;
    r_op[k*3 +: 3] = 3'd2;
    r_wdata[k*32 +: 32] = 32'h1000 + 32'(k);
  endtask

  task automatic all_req(input logic v);
    for (int k = 0; k < 4; k++) set_req(k, v, 1'b0, 12'h300 + 12'(k));
  endtask

  initial begin
    // Reset state
    all_req(1'b0);
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_exc", 32'(rsp_exc), 32'h0);
    chk("rst_op", 32'(csr_op), 32'h0);
    chk("rst_addr", 32'(csr_addr), 32'h0);
    chk("rst_wdata", csr_wdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single request: req0 reads MHARTID
    @(negedge clk); set_req(0, 1'b1, 1'b0, 12'hF14); #1;
    chk("single_ready", 32'(ready), 32'h1);
    chk("single_addr", 32'(csr_addr), 32'hF14);
    chk("single_op", 32'(csr_op), 32'h2);
    chk("single_wdata", csr_wdata, 32'h1000);
    @(negedge clk); set_req(0, 1'b0, 1'b0, 12'h300); #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rdata", rsp_rdata, 32'h0);
    chk("single_exc", 32'(rsp_exc), 32'h0);
    chk("single_idle_ready", 32'(ready), 32'h0);
    chk("single_idle_op", 32'(csr_op), 32'h0);
    use_model = 1'b1;

`ifndef CSR_ARB_HOSTPRIO_EN
    // All four requesters valid: rotation 1,2,3,0,1
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); all_req(1'b1); #1;
      chk("rr_ready", 32'(ready), 32'(1) << g[c]);
      chk("rr_addr", 32'(csr_addr), 32'h300 + 32'(g[c]));
      exp_rv = (c == 0) ? 4'b0 : 4'(1 << g[(c == 0) ? 0 : c-1]);
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (c > 0) chk("rr_rdata", rsp_rdata, 32'hCAFE0300 + 32'(g[c-1]));
    end
    @(negedge clk); all_req(1'b0); #1;
    chk("rr_last_rsp", 32'(rsp_valid), 32'h2);
    chk("rr_last_rdata", rsp_rdata, 32'hCAFE0301);

    // Locked MCYCLE/MCYCLEH pair by requester 2 with others contending
    @(negedge clk); all_req(1'b1); set_req(2, 1'b1, 1'b1, 12'hB00); #1;
    chk("lock1_ready", 32'(ready), 32'h4);
    chk("lock1_addr", 32'(csr_addr), 32'hB00);
    @(negedge clk); set_req(2, 1'b1, 1'b0, 12'hB80); #1;
    chk("lock2_ready", 32'(ready), 32'h4);
    chk("lock2_addr", 32'(csr_addr), 32'hB80);
    chk("lock2_rsp", 32'(rsp_valid), 32'h4);
    chk("lock2_rdata", rsp_rdata, 32'hCAFE0B00);
    @(negedge clk); #1;
    chk("lock3_ready", 32'(ready), 32'h8);
    chk("lock3_rsp", 32'(rsp_valid), 32'h4);
    chk("lock3_rdata", rsp_rdata, 32'hCAFE0B80);
    @(negedge clk); all_req(1'b0); #1;
    chk("lock4_rsp", 32'(rsp_valid), 32'h8);
`else
    // After the host grant rr_ptr is still 0; move it to 3 like the default path.
    @(negedge clk); set_req(3, 1'b1, 1'b0, 12'h303); #1;
    chk("hp_pre_ready", 32'(ready), 32'h8);
    @(negedge clk); all_req(1'b0);
`endif

    // Illegal address raises exc; next clean access clears it
    @(negedge clk); set_req(1, 1'b1, 1'b0, 12'h7C0); exc_drv = 1'b1; #1;
    chk("exc_ready", 32'(ready), 32'h2);
    @(negedge clk); set_req(1, 1'b1, 1'b0, 12'h305); exc_drv = 1'b0; #1;
    chk("exc_b2b_ready", 32'(ready), 32'h2);
    chk("exc_rsp", 32'(rsp_valid), 32'h2);
    chk("exc_flag", 32'(rsp_exc), 32'h1);
    chk("exc_rdata", rsp_rdata, 32'hCAFE07C0);
    @(negedge clk); set_req(1, 1'b0, 1'b0, 12'h301); #1;
    chk("clean_rsp", 32'(rsp_valid), 32'h2);
    chk("clean_flag", 32'(rsp_exc), 32'h0);
    chk("clean_rdata", rsp_rdata, 32'hCAFE0305);
    @(negedge clk); #1;
    chk("hold_rsp", 32'(rsp_valid), 32'h0);
    chk("hold_rdata", rsp_rdata, 32'hCAFE0305);

`ifndef CSR_ARB_HOSTPRIO_EN
    // Lock by requester 3, owner idles, then reset with a response pending
    @(negedge clk); set_req(0, 1'b1, 1'b0, 12'h300); set_req(3, 1'b1, 1'b1, 12'h340); #1;
    chk("rl_ready", 32'(ready), 32'h8);
    @(negedge clk); set_req(3, 1'b0, 1'b1, 12'h340); #1;
    chk("rl_idle_ready", 32'(ready), 32'h0);
    chk("rl_idle_op", 32'(csr_op), 32'h0);
    chk("rl_idle_rsp", 32'(rsp_valid), 32'h8);
    chk("rl_idle_rdata", rsp_rdata, 32'hCAFE0340);
    @(negedge clk); set_req(3, 1'b1, 1'b1, 12'h341); #1;
    chk("rl_again_ready", 32'(ready), 32'h8);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rl_rst_rsp", 32'(rsp_valid), 32'h0);
    chk("rl_rst_rdata", rsp_rdata, 32'h0);
    chk("rl_rst_ready", 32'(ready), 32'h0);
    chk("rl_rst_op", 32'(csr_op), 32'h0);
    chk("rl_rst_addr", 32'(csr_addr), 32'h0);
    @(negedge clk); all_req(1'b1); rst_n = 1'b1; #1;
    chk("rl_post_ready", 32'(ready), 32'h2);
    chk("rl_post_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk); all_req(1'b0);
`else
    // Host priority: req0 beats req3 every cycle until it drops
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); set_req(0, 1'b1, 1'b0, 12'h300); set_req(3, 1'b1, 1'b0, 12'h303); #1;
      chk("hp_ready", 32'(ready), 32'h1);
      chk("hp_addr", 32'(csr_addr), 32'h300);
    end
    @(negedge clk); set_req(0, 1'b0, 1'b0, 12'h300); #1;
    chk("hp_drop_ready", 32'(ready), 32'h8);
    chk("hp_drop_rsp", 32'(rsp_valid), 32'h1);
    @(negedge clk); all_req(1'b0);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
